// File: rtl/weights_loader_pkg.sv
// Shared MLP definitions: weight word type, loader FSM states and the
// weight-count helper used to size the loader memory.
package weights_loader_pkg;

  localparam int unsigned WordW = 32;

  typedef logic [WordW-1:0] weight_t;

  typedef enum logic {
    StIdle,
    StLoad
  } ld_state_e;

  // Words in a two-layer weight set: layer-1 matrix followed by layer-2 matrix.
  function automatic int unsigned total_words(input int unsigned in_dim,
                                              input int unsigned l1_dim,
                                              input int unsigned out_dim);
    return in_dim * l1_dim + l1_dim * out_dim;
  endfunction

endpackage

// File: rtl/weights_loader.sv
// Streams a full two-layer weight set into a local memory through a
// valid/ready handshake and presents it as row-major w1/w2 matrices.
module weights_loader
  import weights_loader_pkg::*;
#(
  parameter int unsigned DATA_W  = WordW,
  parameter int unsigned IN_DIM  = 1,
  parameter int unsigned L1_DIM  = 1,
  parameter int unsigned OUT_DIM = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [DATA_W-1:0]                           in_data,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        weights_valid,
  output logic [L1_DIM-1:0][IN_DIM-1:0][DATA_W-1:0]   w1,
  output logic [OUT_DIM-1:0][L1_DIM-1:0][DATA_W-1:0]  w2
);

  localparam int unsigned Total  = total_words(IN_DIM, L1_DIM, OUT_DIM);
  localparam int unsigned CntW   = $clog2(Total + 1);
  localparam int unsigned W2Base = IN_DIM * L1_DIM;
  localparam logic [CntW-1:0] LastIdx = CntW'(Total - 1);

  ld_state_e        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             wvalid_q, wvalid_d;
  logic             transfer;

  logic [DATA_W-1:0] mem_q [Total];

  assign transfer = (state_q == StLoad) && in_valid;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    wvalid_d = wvalid_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StLoad;
          cnt_d    = '0;
          wvalid_d = 1'b0;
        end
      end
      StLoad: begin
        if (in_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastIdx) begin
            state_d  = StIdle;
            done_d   = 1'b1;
            wvalid_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      wvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      wvalid_q <= wvalid_d;
    end
  end

  // Memory keeps partial contents across reset; reset only blocks the write.
  always_ff @(posedge clk) begin
    for (int k = 0; k < Total; k++) begin
      if (!rst && transfer && (cnt_q == CntW'(k))) begin
        mem_q[k] <= in_data;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < L1_DIM; i++) begin
      for (int j = 0; j < IN_DIM; j++) begin
        w1[i][j] = mem_q[i * IN_DIM + j];
      end
    end
    for (int i = 0; i < OUT_DIM; i++) begin
      for (int j = 0; j < L1_DIM; j++) begin
        w2[i][j] = mem_q[W2Base + i * L1_DIM + j];
      end
    end
  end

  assign in_ready      = (state_q == StLoad);
  assign busy          = (state_q == StLoad);
  assign done          = done_q;
  assign weights_valid = wvalid_q;

endmodule

// File: tb/tb_weights_loader.sv
// Bench for weights_loader with a 2x2 hidden layer and a single output.
module tb_weights_loader;

  localparam int unsigned DW  = 32;
  localparam int unsigned IND = 2;
  localparam int unsigned L1D = 2;
  localparam int unsigned OD  = 1;
  localparam int unsigned TOT = IND * L1D + L1D * OD;

  logic clk = 1'b0;
  logic rst, start, in_valid, in_ready, busy, done, weights_valid;
  logic [DW-1:0] in_data;
  logic [L1D-1:0][IND-1:0][DW-1:0] w1;
  logic [OD-1:0][L1D-1:0][DW-1:0]  w2;

  weights_loader #(
    .DATA_W (DW),
    .IN_DIM (IND),
    .L1_DIM (L1D),
    .OUT_DIM(OD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .busy         (busy),
    .done         (done),
    .weights_valid(weights_valid),
    .w1           (w1),
    .w2           (w2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a load is "open" between an accepted start and the
  // TOT-th accepted word; words fill a flat array in arrival order.
  bit          m_loading = 1'b0;
  int          m_count   = 0;
  bit          m_done    = 1'b0;
  bit          m_wv      = 1'b0;
  logic [31:0] m_mem   [TOT];
  bit          m_known [TOT];

  typedef struct {
    logic        r;
    logic        s;
    logic        v;
    logic [31:0] d;
    logic        e_ready;
    logic        e_busy;
    logic        e_done;
    logic        e_wv;
  } vec_t;

  vec_t vec [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic s, input logic v, input logic [31:0] d);
    if (r) begin
      m_loading = 1'b0;
      m_count   = 0;
      m_done    = 1'b0;
      m_wv      = 1'b0;
    end else begin
      m_done = 1'b0;
      if (!m_loading) begin
        if (s) begin
          m_loading = 1'b1;
          m_count   = 0;
          m_wv      = 1'b0;
        end
      end else if (v) begin
        m_mem[m_count]   = d;
        m_known[m_count] = 1'b1;
        m_count++;
        if (m_count == TOT) begin
          m_loading = 1'b0;
          m_done    = 1'b1;
          m_wv      = 1'b1;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("model_in_ready", in_ready, m_loading);
    chk("model_busy", busy, m_loading);
    chk("model_done", done, m_done);
    chk("model_weights_valid", weights_valid, m_wv);
    for (int i = 0; i < L1D; i++)
      for (int j = 0; j < IND; j++)
        if (m_known[i * IND + j])
          chk($sformatf("model_w1[%0d][%0d]", i, j), w1[i][j], m_mem[i * IND + j]);
    for (int i = 0; i < OD; i++)
      for (int j = 0; j < L1D; j++)
        if (m_known[IND * L1D + i * L1D + j])
          chk($sformatf("model_w2[%0d][%0d]", i, j), w2[i][j], m_mem[IND * L1D + i * L1D + j]);
  endtask

  task automatic step(input logic r, input logic s, input logic v, input logic [31:0] d);
    rst = r; start = s; in_valid = v; in_data = d;
    @(posedge clk);
    model_update(r, s, v, d);
    #1;
    check_model();
  endtask

  task automatic chk_const(input string tag, input logic [31:0] base);
    for (int i = 0; i < L1D; i++)
      for (int j = 0; j < IND; j++)
        chk($sformatf("%s_w1[%0d][%0d]", tag, i, j), w1[i][j], base + 32'(i * IND + j));
    for (int j = 0; j < L1D; j++)
      chk($sformatf("%s_w2[0][%0d]", tag, j), w2[0][j], base + 32'(IND * L1D + j));
  endtask

  initial begin
    int first_done;
    int ndone;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    for (int k = 0; k < TOT; k++) m_known[k] = 1'b0;

    // Basic back-to-back load of 0x10..0x15.
    vec[0] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0};
    vec[1] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0};
    vec[2] = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0};
    vec[3] = '{1'b0, 1'b0, 1'b1, 32'h11, 1'b1, 1'b1, 1'b0, 1'b0};
    vec[4] = '{1'b0, 1'b0, 1'b1, 32'h12, 1'b1, 1'b1, 1'b0, 1'b0};
    vec[5] = '{1'b0, 1'b0, 1'b1, 32'h13, 1'b1, 1'b1, 1'b0, 1'b0};
    vec[6] = '{1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 1'b1, 1'b0, 1'b0};
    vec[7] = '{1'b0, 1'b0, 1'b1, 32'h15, 1'b0, 1'b0, 1'b1, 1'b1};
    vec[8] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 9; k++) begin
      step(vec[k].r, vec[k].s, vec[k].v, vec[k].d);
      chk($sformatf("vec%0d_in_ready", k), in_ready, vec[k].e_ready);
      chk($sformatf("vec%0d_busy", k), busy, vec[k].e_busy);
      chk($sformatf("vec%0d_done", k), done, vec[k].e_done);
      chk($sformatf("vec%0d_wvalid", k), weights_valid, vec[k].e_wv);
    end
    chk_const("b2b", 32'h10);

    // in_valid toggling: sixth word lands on step 11, done follows it.
    step(1'b0, 1'b1, 1'b0, 32'h0);
    first_done = -1;
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b0, (k % 2) == 0, ((k % 2) == 0) ? 32'h10 + 32'(k / 2) : 32'hBAD);
      if (done && first_done < 0) first_done = k + 1;
    end
    chk("alt_done_step", first_done, 11);
    chk("alt_wvalid", weights_valid, 1'b1);
    chk_const("alt", 32'h10);

    // Words offered while idle are ignored.
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 1'b1, 32'hDEAD);
      chk("idle_in_ready", in_ready, 1'b0);
    end
    chk_const("idle", 32'h10);

    // Next load starts at index 0; reset after 3 words aborts it.
    step(1'b0, 1'b1, 1'b1, 32'hDEAD);
    chk("start_valid_w1_00", w1[0][0], 32'h10);
    step(1'b0, 1'b0, 1'b1, 32'h77);
    step(1'b0, 1'b0, 1'b1, 32'h78);
    step(1'b0, 1'b0, 1'b1, 32'h79);
    chk("abort_first_idx", w1[0][0], 32'h77);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("abort_wvalid", weights_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_partial", w1[0][1], 32'h78);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, 1'b1, 32'h20 + 32'(k));
      chk($sformatf("reload_wvalid%0d", k), weights_valid, k == 5);
    end
    chk_const("reload", 32'h20);

    // Reset wins over start and in_valid in the same cycle.
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h50);
    step(1'b1, 1'b1, 1'b1, 32'h51);
    chk("rstprio_busy", busy, 1'b0);
    chk("rstprio_nowrite", w1[0][1], 32'h21);

    // Start during a load is ignored.
    step(1'b0, 1'b1, 1'b0, 32'h0);
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, k == 2, 1'b1, 32'h40 + 32'(k));
      if (done) ndone++;
    end
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (done) ndone++;
    end
    chk("restart_done_count", ndone, 1);
    chk("restart_wvalid", weights_valid, 1'b1);
    chk_const("restart", 32'h40);

    // New start after a complete load drops weights_valid.
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("newload_wvalid", weights_valid, 1'b0);
    chk("newload_busy", busy, 1'b1);
    chk("newload_in_ready", in_ready, 1'b1);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
           $urandom_range(0, 1) == 1, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
